box_sum_col: RTL and testbench

Vertical stage of the box filter. Consumes the per-line horizontal window sums emitted by the 1-D row-sum stage and accumulates them down each column over the last KSZ lines. Each output is the full KSZ×KSZ box sum at the current pixel; the mean/normalise stage consumes it. Uses a KSZ-line ring buffer plus a per-column running-sum memory: one addition and one subtraction per pixel.

---
 rtl/box_sum_col_if.sv | 24 ++
 rtl/box_sum_col.sv | 172 +++++++++++++++++
 tb/tb_box_sum_col.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/box_sum_col_if.sv
// Sample stream between the row-sum stage, the vertical box-sum stage and the
// mean stage: the producer drives the master side, box_sum_col is the slave.
interface box_sum_col_if #(
    parameter int DW = 28,
    parameter int SW = DW + 4
);
    logic          frame_start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [SW-1:0] dout;
    logic          dout_valid;
    logic          dout_full;
    logic          ovf;

    modport master (
        output frame_start, din, din_valid,
        input  dout, dout_valid, dout_full, ovf
    );

    modport slave (
        input  frame_start, din, din_valid,
        output dout, dout_valid, dout_full, ovf
    );
endinterface

// File: rtl/box_sum_col.sv
// Vertical box-filter stage: running column sums over the last KSZ lines, 2-cycle latency.
// Define BOX_SUM_COL_OVF_EN to enable the sticky ovf detector (otherwise ovf is tied low).
module box_sum_col #(
    parameter int DW  = 28,
    parameter int KSZ = 3,
    parameter int IW  = 640,
    parameter int SW  = DW + 4
) (
    input  logic         clk,
    input  logic         rst,
    box_sum_col_if.slave bus
);
    localparam int XW  = $clog2(IW + 1);
    localparam int CAW = $clog2(IW);
    localparam int NW  = $clog2(KSZ + 1);
    localparam int PW  = $clog2(KSZ);
    localparam int RAW = $clog2(KSZ * IW);

    // Line/column bookkeeping
    logic           r_armed;
    logic           r_vld_d;
    logic [XW-1:0]  r_x;
    logic [NW-1:0]  r_n;
    logic [PW-1:0]  r_wp;

    logic           w_acc;
    logic           w_line_end;
    logic           w_in_rng;
    logic           w_frame_clr;
    logic [RAW-1:0] w_ring_addr;
    logic [CAW-1:0] w_csum_raddr;

    // Stage 1
    logic           r_s1_valid;
    logic           r_s1_store;
    logic           r_s1_first;
    logic           r_s1_sub;
    logic           r_s1_full;
    logic [DW-1:0]  r_s1_din;
    logic [CAW-1:0] r_s1_x;
    logic [DW-1:0]  r_old;
    logic [SW-1:0]  r_prev;

    // Stage 2
    logic [SW-1:0]  w_prev;
    logic [SW-1:0]  w_sub;
    logic [SW-1:0]  w_new;
    logic [SW-1:0]  r_dout;
    logic           r_dout_valid;
    logic           r_dout_full;

    logic [DW-1:0]  r_ring [KSZ*IW];
    logic [SW-1:0]  r_csum [IW];

    // A line interrupted by rst is ignored until din_valid drops, so the next
    // rising edge starts line 0 of a fresh frame.
    assign w_acc        = bus.din_valid & r_armed;
    assign w_line_end   = r_vld_d & ~w_acc;
    assign w_in_rng     = (r_x < XW'(IW));
    assign w_frame_clr  = bus.frame_start & ~bus.din_valid;
    assign w_ring_addr  = RAW'(r_wp) * RAW'(IW) + RAW'(r_x);
    assign w_csum_raddr = CAW'(r_x);

    // NOTE: every clocked state update uses <= so all registers sample the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= ~bus.din_valid;
            r_vld_d <= 1'b0;
            r_x     <= '0;
            r_n     <= '0;
            r_wp    <= '0;
        end else begin
            if (!bus.din_valid) begin
                r_armed <= 1'b1;
            end
            r_vld_d <= w_acc;

            if (!w_acc) begin
                r_x <= '0;
            end else if (w_in_rng) begin
                r_x <= r_x + XW'(1);
            end

            if (w_line_end) begin
                r_wp <= (r_wp == PW'(KSZ - 1)) ? '0 : r_wp + PW'(1);
            end

            if (w_frame_clr) begin
                r_n <= '0;
            end else if (w_line_end && (r_n != NW'(KSZ))) begin
                r_n <= r_n + NW'(1);
            end
        end
    end

    // NOTE: the line ring and column-sum memories have no reset; stale
    // contents are masked by the n==0 / n==KSZ gating instead of being cleared.
    always_ff @(posedge clk) begin
        if (w_acc && w_in_rng) begin
            r_old                <= r_ring[w_ring_addr];
            r_ring[w_ring_addr]  <= bus.din;
            r_prev               <= r_csum[w_csum_raddr];
        end
        if (r_s1_valid && r_s1_store) begin
            r_csum[r_s1_x] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_store <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_s1_full  <= 1'b0;
            r_s1_din   <= '0;
            r_s1_x     <= '0;
        end else begin
            r_s1_valid <= w_acc;
            r_s1_store <= w_acc & w_in_rng;
            r_s1_first <= (r_n == '0);
            r_s1_sub   <= (r_n == NW'(KSZ));
            r_s1_full  <= (r_n >= NW'(KSZ - 1));
            r_s1_din   <= bus.din;
            r_s1_x     <= w_csum_raddr;
        end
    end

    assign w_prev = r_s1_first ? '0 : r_prev;
    assign w_sub  = r_s1_sub ? SW'(r_old) : '0;

`ifdef BOX_SUM_COL_OVF_EN
    logic [SW:0] w_sum;
    logic        r_ovf;

    assign w_sum = {1'b0, w_prev} + (SW+1)'(r_s1_din);
    assign w_new = w_sum[SW-1:0] - w_sub;

    always_ff @(posedge clk) begin
        if (rst || w_frame_clr) begin
            r_ovf <= 1'b0;
        end else if (r_s1_valid && (!r_s1_store || w_sum[SW])) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign w_new   = w_prev + SW'(r_s1_din) - w_sub;
    assign bus.ovf = 1'b0;
`endif

    // Pixels past the line buffer still produce a beat, but with a zero sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_full  <= 1'b0;
        end else begin
            r_dout_valid <= r_s1_valid;
            r_dout_full  <= r_s1_valid & r_s1_store & r_s1_full;
            if (r_s1_valid) begin
                r_dout <= r_s1_store ? w_new : '0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_full  = r_dout_full;
endmodule

// File: tb/tb_box_sum_col.sv
// Bench for box_sum_col: a KSZ=3/IW=8 and a KSZ=5/IW=16 instance, each scored
// against a window-sum model (sum of the last KSZ stored lines per column).
module tb_box_sum_col;
    localparam int DW    = 28;
    localparam int SW    = DW + 4;
    localparam int NU    = 2;
    localparam int KSZ_A = 3;
    localparam int IW_A  = 8;
    localparam int KSZ_B = 5;
    localparam int IW_B  = 16;
`ifdef BOX_SUM_COL_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [SW-1:0] dout;
        logic          full;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    box_sum_col_if #(.DW(DW), .SW(SW)) bus_a ();
    box_sum_col_if #(.DW(DW), .SW(SW)) bus_b ();

    box_sum_col #(.DW(DW), .KSZ(KSZ_A), .IW(IW_A), .SW(SW)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    box_sum_col #(.DW(DW), .KSZ(KSZ_B), .IW(IW_B), .SW(SW)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [DW-1:0] d_din [NU];
    logic          d_vld [NU];
    logic          d_fs  [NU];
    logic [SW-1:0] q_dout [NU];
    logic          q_vld  [NU];
    logic          q_full [NU];
    logic          q_ovf  [NU];

    assign bus_a.din         = d_din[0];
    assign bus_a.din_valid   = d_vld[0];
    assign bus_a.frame_start = d_fs[0];
    assign bus_b.din         = d_din[1];
    assign bus_b.din_valid   = d_vld[1];
    assign bus_b.frame_start = d_fs[1];
    assign q_dout[0] = bus_a.dout;
    assign q_vld[0]  = bus_a.dout_valid;
    assign q_full[0] = bus_a.dout_full;
    assign q_ovf[0]  = bus_a.ovf;
    assign q_dout[1] = bus_b.dout;
    assign q_vld[1]  = bus_b.dout_valid;
    assign q_full[1] = bus_b.dout_full;
    assign q_ovf[1]  = bus_b.ovf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int     ksz [NU] = '{KSZ_A, KSZ_B};
    int     iw  [NU] = '{IW_A, IW_B};
    int     line_k [NU];
    longint hist [NU][16][16];
    exp_t   exp_a [$];
    exp_t   exp_b [$];
    logic   mon_en [NU];
    logic   vh [NU][2];

    function automatic exp_t model(input int u, input int x, input logic [DW-1:0] v);
        exp_t   e;
        longint s = longint'(v);
        int     k = line_k[u];
        if (x >= iw[u]) begin
            e.dout = '0;
            e.full = 1'b0;
            return e;
        end
        for (int j = 1; j < ksz[u] && j <= k; j++) begin
            s += hist[u][(k - j) % 16][x];
        end
        e.dout = s[SW-1:0];
        e.full = (k >= ksz[u] - 1);
        return e;
    endfunction

    task automatic push_exp(input int u, input exp_t e);
        if (u == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    function automatic int exp_size(input int u);
        return (u == 0) ? exp_a.size() : exp_b.size();
    endfunction

    task automatic monitor_unit(input int u);
        exp_t e;
        check($sformatf("vld_align_u%0d", u), SW'(q_vld[u]), SW'(vh[u][1]));
        if (q_vld[u]) begin
            if (exp_size(u) == 0) begin
                check($sformatf("extra_beat_u%0d", u), SW'(q_vld[u]), '0);
            end else begin
                e = (u == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check($sformatf("dout_u%0d", u), q_dout[u], e.dout);
                check($sformatf("full_u%0d", u), SW'(q_full[u]), SW'(e.full));
            end
        end
    endtask

    always @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            vh[u][1] <= vh[u][0];
            vh[u][0] <= d_vld[u];
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (mon_en[u]) monitor_unit(u);
        end
    end

    // mode 0: constant base, 1: base + x ramp, otherwise random
    task automatic drive_line(input int u, input int len, input int mode, input int base, input int gap);
        logic [DW-1:0] v;
        for (int x = 0; x < len; x++) begin
            case (mode)
                0:       v = DW'(base);
                1:       v = DW'(base + x);
                default: v = DW'($urandom);
            endcase
            push_exp(u, model(u, x, v));
            if (x < iw[u]) hist[u][line_k[u] % 16][x] = longint'(v);
            d_din[u] = v;
            d_vld[u] = 1'b1;
            @(posedge clk); #1;
        end
        d_vld[u] = 1'b0;
        d_din[u] = '0;
        line_k[u]++;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic frame_start(input int u);
        d_fs[u] = 1'b1;
        @(posedge clk); #1;
        d_fs[u] = 1'b0;
        line_k[u] = 0;
    endtask

    task automatic wait_idle(input int u);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check($sformatf("drained_u%0d", u), SW'(exp_size(u)), '0);
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            d_din[u]  = '0;
            d_vld[u]  = 1'b0;
            d_fs[u]   = 1'b0;
            mon_en[u] = 1'b0;
            line_k[u] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check($sformatf("rst_dout_u%0d", u), q_dout[u], '0);
            check($sformatf("rst_vld_u%0d", u), SW'(q_vld[u]), '0);
            check($sformatf("rst_full_u%0d", u), SW'(q_full[u]), '0);
            check($sformatf("rst_ovf_u%0d", u), SW'(q_ovf[u]), '0);
        end
        @(posedge clk); #1;
        mon_en[0] = 1'b1;
        mon_en[1] = 1'b1;

        // Constant lines 1..4: sums 1,3,6,9
        for (int k = 0; k < 4; k++) drive_line(0, 8, 0, k + 1, 2);
        // New frame of all-5 lines: 5,10,15,15
        frame_start(0);
        for (int k = 0; k < 4; k++) drive_line(0, 8, 0, 5, 2);
        // Ramp din = 10k + x; line 4 gives 90 + 3x
        frame_start(0);
        for (int k = 0; k < 5; k++) drive_line(0, 8, 1, 10 * k, 2);
        // Random lines with mixed gaps
        frame_start(0);
        for (int k = 0; k < 6; k++) drive_line(0, 8, 2, 0, int'($urandom_range(1, 3)));
        wait_idle(0);
        check("ovf_before", SW'(q_ovf[0]), '0);

        // Over-long line: pixels 8 and 9 are not stored
        drive_line(0, 10, 2, 0, 2);
        wait_idle(0);
        check("ovf_after_long", SW'(q_ovf[0]), SW'(OVF_EXP));
        drive_line(0, 8, 2, 0, 2);
        drive_line(0, 8, 2, 0, 2);
        wait_idle(0);
        check("ovf_sticky", SW'(q_ovf[0]), SW'(OVF_EXP));
        frame_start(0);
        @(negedge clk);
        check("ovf_cleared", SW'(q_ovf[0]), '0);
        @(posedge clk); #1;

        // Reset in the middle of line 2
        drive_line(0, 8, 2, 0, 2);
        drive_line(0, 8, 2, 0, 2);
        wait_idle(0);
        mon_en[0] = 1'b0;
        for (int x = 0; x < 8; x++) begin
            d_din[0] = DW'($urandom);
            d_vld[0] = 1'b1;
            if (x == 4) rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            if (x >= 4) begin
                @(negedge clk);
                check("midrst_vld", SW'(q_vld[0]), '0);
                check("midrst_dout", q_dout[0], '0);
                check("midrst_full", SW'(q_full[0]), '0);
            end
        end
        d_vld[0] = 1'b0;
        d_din[0] = '0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_tail_vld", SW'(q_vld[0]), '0);
        end
        check("midrst_ovf", SW'(q_ovf[0]), '0);
        line_k[0] = 0;
        line_k[1] = 0;
        @(posedge clk); #1;
        mon_en[0] = 1'b1;
        drive_line(0, 8, 0, 9, 2);
        drive_line(0, 8, 2, 0, 2);
        drive_line(0, 8, 2, 0, 2);
        drive_line(0, 8, 2, 0, 2);
        wait_idle(0);

        // KSZ=5: 20 random full-width lines with 1-cycle gaps
        for (int k = 0; k < 20; k++) drive_line(1, IW_B, 2, 0, 1);
        wait_idle(1);
        check("ovf_b", SW'(q_ovf[1]), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
